data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe_if.sv | 29 ++
 rtl/data_mem_pipe.sv | 154 +++++++++++++++
 tb/tb_data_mem_pipe.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pipe_if.sv
// Request/response/clear bundle for the pipelined data memory.
// The master drives requests and the clear pulse; the slave (memory) returns
// readiness, sweep status and responses.
interface data_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  mem_clear;
    logic                  clear_busy;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, mem_clear,
        input  req_ready, clear_busy, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, mem_clear,
        output req_ready, clear_busy, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_pipe.sv
// Word-organised data memory with byte-enabled writes, a fixed-latency
// response pipeline (1 or 2 cycles) and a whole-array zero sweep.
// Memory contents are not touched by reset; only control state is.
module data_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_pipe_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int OFF  = $clog2(BE_W);
    localparam int AW   = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready;
    logic            busy;
    logic            clr_en;

    // Power-up image of the array; everything not listed starts at zero.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{
        0: DATA_W'(0),  1: DATA_W'(32), 2: DATA_W'(40),
        3: DATA_W'(47), 4: DATA_W'(7),  5: DATA_W'(100),
        default: '0
    };

    logic            accept;
    logic            addr_err;
    logic            wr_en;
    logic [AW-1:0]   word_idx;

    logic                vld_p1_d, vld_p1_q;
    logic                err_p1_d, err_p1_q;
    logic [DATA_W-1:0]   rdata_p1_d, rdata_p1_q;

    logic                rsp_vld;
    logic                rsp_err_raw;
    logic [DATA_W-1:0]   rsp_data_raw;

    // Sweep FSM: next state, sweep counter and handshake/status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        busy    = 1'b0;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.mem_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request decode and stage-1 capture; read data is sampled before any
    // write on the same edge, and writes/errors carry zero data.
    always_comb begin
        word_idx   = bus.req_addr[OFF +: AW];
        addr_err   = (bus.req_addr[OFF-1:0] != '0) ||
                     ((bus.req_addr >> (OFF + AW)) != '0);
        accept     = bus.req_valid && ready;
        wr_en      = accept && bus.req_write && !addr_err;
        vld_p1_d   = accept;
        err_p1_d   = addr_err;
        rdata_p1_d = (accept && !bus.req_write && !addr_err) ? mem_q[word_idx] : '0;
    end

    // Control state: FSM, sweep counter and the stage-1 valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    // Stage-1 payload; only meaningful while vld_p1_q is set.
    always_ff @(posedge clk) begin
        err_p1_q   <= err_p1_d;
        rdata_p1_q <= rdata_p1_d;
    end

    // Array update: the sweep and accepted requests never coincide.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.req_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              vld_p2_q;
        logic              err_p2_q;
        logic [DATA_W-1:0] rdata_p2_q;

        // Stage-2 valid, cleared by reset so in-flight responses are dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p2_q <= 1'b0;
            end else begin
                vld_p2_q <= vld_p1_q;
            end
        end

        // Stage-2 payload.
        always_ff @(posedge clk) begin
            err_p2_q   <= err_p1_q;
            rdata_p2_q <= rdata_p1_q;
        end

        assign rsp_vld      = vld_p2_q;
        assign rsp_err_raw  = err_p2_q;
        assign rsp_data_raw = rdata_p2_q;
    end else begin : g_lat1
        assign rsp_vld      = vld_p1_q;
        assign rsp_err_raw  = err_p1_q;
        assign rsp_data_raw = rdata_p1_q;
    end

    // Payload is masked by the valid so idle/reset outputs read as zero.
    assign bus.req_ready  = ready;
    assign bus.clear_busy = busy;
    assign bus.rsp_valid  = rsp_vld;
    assign bus.rsp_err    = rsp_vld & rsp_err_raw;
    assign bus.rsp_rdata  = rsp_vld ? rsp_data_raw : '0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: a latency-1 instance exercised for
// reads, writes, errors and sweeps, plus a latency-2 instance for
// back-to-back ordering and reset flush. Expected responses are queued by a
// reference model when requests are driven and popped when due.
module tb_data_mem_pipe;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_mem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifa ();
    data_mem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifb ();

    data_mem_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    data_mem_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          clr_left = 0;
    int          busy_cycles = 0;
    logic [31:0] init_w  [DEPTH];
    logic [31:0] model_a [DEPTH];
    rsp_t        qa[$];
    rsp_t        qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ifa.req_valid = 1'b1;
        ifa.req_write = w;
        ifa.req_addr  = a;
        ifa.req_wdata = d;
        ifa.req_be    = be;
    endtask

    task automatic idle_a();
        ifa.req_valid = 1'b0;
        ifa.req_write = 1'b0;
        ifa.req_addr  = '0;
        ifa.req_wdata = '0;
        ifa.req_be    = '0;
    endtask

    task automatic req_b(input logic [31:0] a);
        ifb.req_valid = 1'b1;
        ifb.req_write = 1'b0;
        ifb.req_addr  = a;
        ifb.req_wdata = '0;
        ifb.req_be    = '0;
    endtask

    task automatic idle_b();
        ifb.req_valid = 1'b0;
        ifb.req_write = 1'b0;
        ifb.req_addr  = '0;
        ifb.req_wdata = '0;
        ifb.req_be    = '0;
    endtask

    // Advance one clock: update the model with what the DUTs see at the
    // coming edge, then check outputs 1 time unit after it.
    task automatic tick();
        int   idx;
        logic err;
        rsp_t r;
        if (rst_n) begin
            if (ifa.req_valid && clr_left == 0) begin
                idx = int'(ifa.req_addr >> 2);
                err = (ifa.req_addr[1:0] != 2'b00) || (idx >= DEPTH);
                r.due = cyc + 1;
                r.rdata = 32'h0;
                r.err = err;
                if (!err && ifa.req_write) begin
                    for (int b = 0; b < 4; b++)
                        if (ifa.req_be[b]) model_a[idx][8*b +: 8] = ifa.req_wdata[8*b +: 8];
                end else if (!err) begin
                    r.rdata = model_a[idx];
                end
                qa.push_back(r);
            end
            if (clr_left > 0) begin
                model_a[DEPTH - clr_left] = 32'h0;
                clr_left--;
            end else if (ifa.mem_clear) begin
                clr_left = DEPTH;
            end
            if (ifb.req_valid) begin
                r.due = cyc + 2;
                r.rdata = init_w[int'(ifb.req_addr >> 2)];
                r.err = 1'b0;
                qb.push_back(r);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("a_req_ready", {31'b0, ifa.req_ready}, {31'b0, clr_left == 0});
        chk("a_clear_busy", {31'b0, ifa.clear_busy}, {31'b0, clr_left != 0});
        chk("b_req_ready", {31'b0, ifb.req_ready}, 32'd1);
        if (ifa.clear_busy) busy_cycles++;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            r = qa.pop_front();
            chk("a_rsp_valid", {31'b0, ifa.rsp_valid}, 32'd1);
            chk("a_rsp_rdata", ifa.rsp_rdata, r.rdata);
            chk("a_rsp_err", {31'b0, ifa.rsp_err}, {31'b0, r.err});
        end else begin
            chk("a_rsp_valid_idle", {31'b0, ifa.rsp_valid}, 32'd0);
            chk("a_rsp_rdata_idle", ifa.rsp_rdata, 32'd0);
            chk("a_rsp_err_idle", {31'b0, ifa.rsp_err}, 32'd0);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            r = qb.pop_front();
            chk("b_rsp_valid", {31'b0, ifb.rsp_valid}, 32'd1);
            chk("b_rsp_rdata", ifb.rsp_rdata, r.rdata);
            chk("b_rsp_err", {31'b0, ifb.rsp_err}, {31'b0, r.err});
        end else begin
            chk("b_rsp_valid_idle", {31'b0, ifb.rsp_valid}, 32'd0);
            chk("b_rsp_rdata_idle", ifb.rsp_rdata, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) init_w[i] = 32'h0;
        init_w[1] = 32'd32;
        init_w[2] = 32'd40;
        init_w[3] = 32'd47;
        init_w[4] = 32'd7;
        init_w[5] = 32'd100;
        for (int i = 0; i < DEPTH; i++) model_a[i] = init_w[i];

        idle_a();
        idle_b();
        ifa.mem_clear = 1'b0;
        ifb.mem_clear = 1'b0;

        // Reset state, then first cycle after release.
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back reads of default contents.
        req_a(1'b0, 32'h4, 32'h0, 4'h0);   tick();
        req_a(1'b0, 32'h14, 32'h0, 4'h0);  tick();
        idle_a(); tick(); tick();

        // Partial-byte write followed immediately by a read of the same word.
        req_a(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101); tick();
        req_a(1'b0, 32'h8, 32'h0, 4'h0);           tick();
        idle_a(); tick(); tick();

        // Misaligned and out-of-range accesses.
        req_a(1'b0, 32'h6, 32'h0, 4'h0);           tick();
        req_a(1'b0, 32'h100, 32'h0, 4'h0);         tick();
        req_a(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);  tick();
        req_a(1'b1, 32'h102, 32'hFFFFFFFF, 4'hF);  tick();
        idle_a(); tick();

        // Read back every word to confirm only the intended bytes changed.
        for (int i = 0; i < DEPTH; i++) begin
            req_a(1'b0, 32'(i * 4), 32'h0, 4'h0);
            tick();
        end
        idle_a(); tick();

        // Latency-2 instance: four back-to-back reads.
        req_b(32'h0); tick();
        req_b(32'h4); tick();
        req_b(32'h8); tick();
        req_b(32'hC); tick();
        idle_b(); tick(); tick(); tick();

        // Clear pulse coincident with an accepted read; requests refused meanwhile.
        busy_cycles = 0;
        req_a(1'b0, 32'h10, 32'h0, 4'h0);
        ifa.mem_clear = 1'b1;
        tick();
        ifa.mem_clear = 1'b0;
        req_a(1'b0, 32'h0, 32'h0, 4'h0);
        tick(); tick(); tick();
        idle_a();
        for (int k = 0; k < 100 && clr_left > 0; k++) tick();
        chk("clear_timeout", 32'(clr_left), 32'd0);
        tick();
        chk("clear_len", 32'(busy_cycles), 32'd64);
        req_a(1'b0, 32'hC, 32'h0, 4'h0);  tick();
        req_a(1'b0, 32'h10, 32'h0, 4'h0); tick();
        idle_a(); tick(); tick();

        // Seed words, start a sweep (extra mem_clear ignored), reset at word 10.
        req_a(1'b1, 32'h14, 32'hCAFEF00D, 4'hF); tick();
        req_a(1'b1, 32'h28, 32'h0A0A0A0A, 4'hF); tick();
        req_a(1'b1, 32'h50, 32'h12345678, 4'hF); tick();
        idle_a(); tick();
        ifa.mem_clear = 1'b1;
        tick(); tick(); tick(); tick();
        ifa.mem_clear = 1'b0;
        for (int k = 0; k < 100 && clr_left > DEPTH - 9; k++) tick();
        req_b(32'h14);
        tick();
        idle_b();
        chk("sweep_pos", 32'(clr_left), 32'(DEPTH - 10));
        rst_n = 1'b0;
        #1;
        chk("rst_clear_busy", {31'b0, ifa.clear_busy}, 32'd0);
        chk("rst_req_ready", {31'b0, ifa.req_ready}, 32'd1);
        chk("rst_a_rsp_valid", {31'b0, ifa.rsp_valid}, 32'd0);
        chk("rst_b_rsp_valid", {31'b0, ifb.rsp_valid}, 32'd0);
        qa.delete();
        qb.delete();
        clr_left = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Words below the interrupted sweep point are zero; the rest survive.
        req_a(1'b0, 32'h14, 32'h0, 4'h0); tick();
        req_a(1'b0, 32'h24, 32'h0, 4'h0); tick();
        req_a(1'b0, 32'h28, 32'h0, 4'h0); tick();
        req_a(1'b0, 32'h50, 32'h0, 4'h0); tick();
        idle_a(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
